// File: rtl/butterfly_radix4_pipe.sv
// Fully pipelined radix-4 DIF butterfly: one 4-point complex set per clock, 4-cycle latency,
// forward/inverse mode, per-sample scaling, round-half-up, saturation and sticky overflow.
module butterfly_radix4_pipe #(
  parameter int DATA_W  = 32,
  parameter int TW_W    = 16,
  parameter int LATENCY = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic                     inv,
  input  logic [1:0]               scale,
  input  logic signed [DATA_W-1:0] ar,
  input  logic signed [DATA_W-1:0] ai,
  input  logic signed [DATA_W-1:0] br,
  input  logic signed [DATA_W-1:0] bi,
  input  logic signed [DATA_W-1:0] cr,
  input  logic signed [DATA_W-1:0] ci,
  input  logic signed [DATA_W-1:0] dr,
  input  logic signed [DATA_W-1:0] di,
  input  logic signed [TW_W-1:0]   w0r,
  input  logic signed [TW_W-1:0]   w0i,
  input  logic signed [TW_W-1:0]   w1r,
  input  logic signed [TW_W-1:0]   w1i,
  input  logic signed [TW_W-1:0]   w2r,
  input  logic signed [TW_W-1:0]   w2i,
  input  logic                     clear_ovf,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out0r,
  output logic signed [DATA_W-1:0] out0i,
  output logic signed [DATA_W-1:0] out1r,
  output logic signed [DATA_W-1:0] out1i,
  output logic signed [DATA_W-1:0] out2r,
  output logic signed [DATA_W-1:0] out2i,
  output logic signed [DATA_W-1:0] out3r,
  output logic signed [DATA_W-1:0] out3i,
  output logic                     ovf
);

  localparam int SW = DATA_W + 2;
  localparam int PW = DATA_W + TW_W + 3;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] v,
                                                       input logic [7:0]           sh);
    logic signed [PW-1:0] bias;
    logic signed [PW-1:0] sum;
    if (sh != 8'd0) begin
      bias = {{(PW-1){1'b0}}, 1'b1} << (sh - 8'd1);
    end else begin
      bias = '0;
    end
    sum = v + bias;
    return sum >>> sh;
  endfunction

  function automatic logic is_sat(input logic signed [PW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic [DATA_W-1:0] clamp(input logic signed [PW-1:0] v);
    logic [DATA_W-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DATA_W-1:0];
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

  logic [LATENCY-1:0]     vld_q;
  logic                   inv1_q;
  logic [1:0]             sc_in_d, sc1_q, sc2_q, sc3_q;
  logic signed [SW-1:0]   st1_d [8];
  logic signed [SW-1:0]   st1_q [8];
  logic signed [SW-1:0]   st2_d [8];
  logic signed [SW-1:0]   st2_q [8];
  logic signed [PW-1:0]   st3_d [8];
  logic signed [PW-1:0]   st3_q [8];
  logic signed [TW_W-1:0] tw_in [6];
  logic signed [TW_W-1:0] tw1_q [6];
  logic signed [TW_W-1:0] tw2_q [6];
  logic [DATA_W-1:0]      out_d [8];
  logic [DATA_W-1:0]      out_q [8];
  logic                   ovf_d, ovf_q;
  logic [7:0]             sh_s;
  logic signed [PW-1:0]   rnd_s;
  logic                   clamp_any_s;

  assign tw_in[0] = w0r;
  assign tw_in[1] = w0i;
  assign tw_in[2] = w1r;
  assign tw_in[3] = w1i;
  assign tw_in[4] = w2r;
  assign tw_in[5] = w2i;

  // S1: radix-2 sums a+c, a-c, b+d, b-d (re/im pairs); scale 3 collapses to 2
  always_comb begin
    st1_d[0] = SW'(ar) + SW'(cr);
    st1_d[1] = SW'(ai) + SW'(ci);
    st1_d[2] = SW'(ar) - SW'(cr);
    st1_d[3] = SW'(ai) - SW'(ci);
    st1_d[4] = SW'(br) + SW'(dr);
    st1_d[5] = SW'(bi) + SW'(di);
    st1_d[6] = SW'(br) - SW'(dr);
    st1_d[7] = SW'(bi) - SW'(di);
    sc_in_d  = (scale == 2'd3) ? 2'd2 : scale;
  end

  // S2: X0/X2 partials plus the +/-j rotation of (b-d) for X1/X3
  always_comb begin
    st2_d[0] = st1_q[0] + st1_q[4];
    st2_d[1] = st1_q[1] + st1_q[5];
    st2_d[4] = st1_q[0] - st1_q[4];
    st2_d[5] = st1_q[1] - st1_q[5];
    if (inv1_q) begin
      st2_d[2] = st1_q[2] - st1_q[7];
      st2_d[3] = st1_q[3] + st1_q[6];
      st2_d[6] = st1_q[2] + st1_q[7];
      st2_d[7] = st1_q[3] - st1_q[6];
    end else begin
      st2_d[2] = st1_q[2] + st1_q[7];
      st2_d[3] = st1_q[3] - st1_q[6];
      st2_d[6] = st1_q[2] - st1_q[7];
      st2_d[7] = st1_q[3] + st1_q[6];
    end
  end

  // S3: full-precision complex twiddle products; X0 bypasses the multiplier
  always_comb begin
    st3_d[0] = PW'(st2_q[0]);
    st3_d[1] = PW'(st2_q[1]);
    for (int k = 1; k < 4; k++) begin
      st3_d[2*k]   = PW'(st2_q[2*k]) * PW'(tw2_q[2*k-2]) - PW'(st2_q[2*k+1]) * PW'(tw2_q[2*k-1]);
      st3_d[2*k+1] = PW'(st2_q[2*k]) * PW'(tw2_q[2*k-1]) + PW'(st2_q[2*k+1]) * PW'(tw2_q[2*k-2]);
    end
  end

  // S4: round-half-up, scale, saturate; outputs only change on a valid sample
  always_comb begin
    sh_s        = 8'd0;
    rnd_s       = '0;
    clamp_any_s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sh_s        = (i < 2) ? {6'd0, sc3_q} : (8'(TW_W - 1) + {6'd0, sc3_q});
      rnd_s       = round_shift(st3_q[i], sh_s);
      clamp_any_s = clamp_any_s | is_sat(rnd_s);
      out_d[i]    = vld_q[LATENCY-2] ? clamp(rnd_s) : out_q[i];
    end
    ovf_d = (vld_q[LATENCY-2] & clamp_any_s) | (ovf_q & ~clear_ovf);
  end

  // Pipeline and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_q  <= '0;
      inv1_q <= 1'b0;
      sc1_q  <= 2'd0;
      sc2_q  <= 2'd0;
      sc3_q  <= 2'd0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        st1_q[i] <= '0;
        st2_q[i] <= '0;
        st3_q[i] <= '0;
        out_q[i] <= '0;
      end
      for (int i = 0; i < 6; i++) begin
        tw1_q[i] <= '0;
        tw2_q[i] <= '0;
      end
    end else begin
      vld_q  <= {vld_q[LATENCY-2:0], in_valid};
      inv1_q <= inv;
      sc1_q  <= sc_in_d;
      sc2_q  <= sc1_q;
      sc3_q  <= sc2_q;
      ovf_q  <= ovf_d;
      for (int i = 0; i < 8; i++) begin
        st1_q[i] <= st1_d[i];
        st2_q[i] <= st2_d[i];
        st3_q[i] <= st3_d[i];
        out_q[i] <= out_d[i];
      end
      for (int i = 0; i < 6; i++) begin
        tw1_q[i] <= tw_in[i];
        tw2_q[i] <= tw1_q[i];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign ovf       = ovf_q;
  assign out0r     = out_q[0];
  assign out0i     = out_q[1];
  assign out1r     = out_q[2];
  assign out1i     = out_q[3];
  assign out2r     = out_q[4];
  assign out2i     = out_q[5];
  assign out3r     = out_q[6];
  assign out3i     = out_q[7];

endmodule

// File: tb/tb_butterfly_radix4_pipe.sv
// Table-driven bench for butterfly_radix4_pipe: directed vectors with hand-computed results
// plus reset, streaming, set-wins and mid-flight reset sequences.
module tb_butterfly_radix4_pipe;

  localparam int DW = 32;
  localparam int TW = 16;
  localparam int NV = 9;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef longint arr8_t [8];
  typedef longint arr6_t [6];

  typedef struct {
    string      name;
    logic       inv;
    logic [1:0] scale;
    arr8_t      d;
    arr6_t      w;
    arr8_t      x;
    logic       ovf;
  } vec_t;

  logic                 clock = 1'b0;
  logic                 resetn, in_valid, inv, clear_ovf;
  logic [1:0]           scale;
  logic signed [DW-1:0] din  [8];
  logic signed [TW-1:0] tw   [6];
  logic signed [DW-1:0] dout [8];
  logic                 out_valid, ovf;
  logic signed [DW-1:0] out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t  vt [NV];
  arr6_t w_half, w_neg1;

  butterfly_radix4_pipe #(.DATA_W(DW), .TW_W(TW), .LATENCY(4)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .inv(inv), .scale(scale),
    .ar(din[0]), .ai(din[1]), .br(din[2]), .bi(din[3]),
    .cr(din[4]), .ci(din[5]), .dr(din[6]), .di(din[7]),
    .w0r(tw[0]), .w0i(tw[1]), .w1r(tw[2]), .w1i(tw[3]), .w2r(tw[4]), .w2i(tw[5]),
    .clear_ovf(clear_ovf), .out_valid(out_valid),
    .out0r(out0r), .out0i(out0i), .out1r(out1r), .out1i(out1i),
    .out2r(out2r), .out2i(out2i), .out3r(out3r), .out3i(out3i), .ovf(ovf)
  );

  assign dout[0] = out0r;
  assign dout[1] = out0i;
  assign dout[2] = out1r;
  assign dout[3] = out1i;
  assign dout[4] = out2r;
  assign dout[5] = out2i;
  assign dout[6] = out3r;
  assign dout[7] = out3i;

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int v);
    inv   = vt[v].inv;
    scale = vt[v].scale;
    for (int i = 0; i < 8; i++) din[i] = DW'(vt[v].d[i]);
    for (int i = 0; i < 6; i++) tw[i] = TW'(vt[v].w[i]);
  endtask

  initial begin
    int   edge_n;
    int   sk [9];
    int   s;
    logic ev;
    longint last;

    w_half = '{16384, 0, 16384, 0, 16384, 0};
    w_neg1 = '{-32768, 0, -32768, 0, -32768, 0};
    vt[0].name = "half_a";     vt[0].inv = 1'b0; vt[0].scale = 2'd0; vt[0].ovf = 1'b0; vt[0].w = w_half;
    vt[0].d = '{100, 0, 0, 0, 0, 0, 0, 0};       vt[0].x = '{100, 0, 50, 0, 50, 0, 50, 0};
    vt[1].name = "neg1_b_fwd"; vt[1].inv = 1'b0; vt[1].scale = 2'd0; vt[1].ovf = 1'b0; vt[1].w = w_neg1;
    vt[1].d = '{0, 0, 10, 0, 0, 0, 0, 0};        vt[1].x = '{10, 0, 0, 10, 10, 0, 0, -10};
    vt[2].name = "neg1_b_inv"; vt[2].inv = 1'b1; vt[2].scale = 2'd0; vt[2].ovf = 1'b0; vt[2].w = w_neg1;
    vt[2].d = '{0, 0, 10, 0, 0, 0, 0, 0};        vt[2].x = '{10, 0, 0, -10, 10, 0, 0, 10};
    vt[3].name = "sat_pos";    vt[3].inv = 1'b0; vt[3].scale = 2'd0; vt[3].ovf = 1'b1; vt[3].w = w_half;
    vt[3].d = '{MAXV, 0, MAXV, 0, MAXV, 0, MAXV, 0}; vt[3].x = '{MAXV, 0, 0, 0, 0, 0, 0, 0};
    vt[4].name = "sat_scale2"; vt[4].inv = 1'b0; vt[4].scale = 2'd2; vt[4].ovf = 1'b0; vt[4].w = w_half;
    vt[4].d = '{MAXV, 0, MAXV, 0, MAXV, 0, MAXV, 0}; vt[4].x = '{MAXV, 0, 0, 0, 0, 0, 0, 0};
    vt[5].name = "scale3";     vt[5].inv = 1'b0; vt[5].scale = 2'd3; vt[5].ovf = 1'b0; vt[5].w = w_half;
    vt[5].d = '{7, -7, 0, 0, 0, 0, 0, 0};        vt[5].x = '{2, -2, 1, -1, 1, -1, 1, -1};
    vt[6].name = "cplx_tw";    vt[6].inv = 1'b0; vt[6].scale = 2'd0; vt[6].ovf = 1'b0;
    vt[6].w = '{23170, -23170, 0, -32768, -32768, 0};
    vt[6].d = '{1000, 2000, 0, 0, 0, 0, 0, 0};   vt[6].x = '{1000, 2000, 2121, 707, 2000, -1000, -1000, -2000};
    vt[7].name = "sat_neg";    vt[7].inv = 1'b0; vt[7].scale = 2'd0; vt[7].ovf = 1'b1;
    vt[7].w = '{16384, 0, -32768, 0, 16384, 0};
    vt[7].d = '{MAXV, 0, MINV, 0, MAXV, 0, MINV, 0}; vt[7].x = '{-2, 0, 0, 0, MINV, 0, 0, 0};
    vt[8].name = "inv_d";      vt[8].inv = 1'b1; vt[8].scale = 2'd0; vt[8].ovf = 1'b0; vt[8].w = w_half;
    vt[8].d = '{0, 0, 0, 0, 0, 0, 3, 5};         vt[8].x = '{3, 5, 3, -1, -1, -2, -2, 2};

    // Reset held with random traffic
    resetn = 1'b0; in_valid = 1'b1; inv = 1'b0; scale = 2'd0; clear_ovf = 1'b0;
    for (int i = 0; i < 6; i++) tw[i] = TW'($urandom());
    repeat (3) begin
      for (int i = 0; i < 8; i++) din[i] = DW'($urandom());
      tick();
    end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_out%0d", i), dout[i], 0);

    // Release: first out_valid 4 edges after the first sampled in_valid
    resetn = 1'b1;
    tick();
    in_valid = 1'b0;
    edge_n = 1;
    while (!out_valid && edge_n < 10) begin
      tick();
      edge_n++;
    end
    chk("first_valid_latency", edge_n, 4);

    // Directed table
    for (int v = 0; v < NV; v++) begin
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      load(v);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk($sformatf("%s_early_valid", vt[v].name), out_valid, 0);
      tick();
      chk($sformatf("%s_valid", vt[v].name), out_valid, 1);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_x%0d", vt[v].name, i), dout[i], vt[v].x[i]);
      chk($sformatf("%s_ovf", vt[v].name), ovf, vt[v].ovf);
      tick();
      chk($sformatf("%s_valid_drop", vt[v].name), out_valid, 0);
      chk($sformatf("%s_hold", vt[v].name), out0r, vt[v].x[0]);
    end

    // Streaming with a bubble and per-sample scale toggling
    sk = '{1, 2, 3, 4, 0, 5, 6, 7, 8};
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = '0;
    for (int i = 0; i < 6; i++) tw[i] = TW'(w_half[i]);
    inv = 1'b0;
    last = vt[NV-1].x[0];
    for (int t = 0; t < 13; t++) begin
      if (t < 9 && sk[t] != 0) begin
        in_valid = 1'b1;
        din[0]   = DW'(sk[t]);
        scale    = (sk[t] % 2 == 0) ? 2'd1 : 2'd0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (t >= 3) begin
        s  = t - 3;
        ev = (s < 9) ? (sk[s] != 0) : 1'b0;
        chk($sformatf("stream_valid_t%0d", t), out_valid, ev);
        if (ev) last = (sk[s] % 2 == 0) ? longint'((sk[s] + 1) / 2) : longint'(sk[s]);
        chk($sformatf("stream_out0r_t%0d", t), out0r, last);
      end
    end
    chk("stream_ovf", ovf, 0);

    // Overflow and clear_ovf in the same cycle: set wins
    clear_ovf = 1'b1;
    load(3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("setwins_ovf", ovf, 1);
    tick();
    chk("setwins_cleared", ovf, 0);
    clear_ovf = 1'b0;

    // Reset with three sets in flight after the first has emerged
    in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    chk("midrst_pre_valid", out_valid, 1);
    chk("midrst_pre_ovf", ovf, 1);
    resetn = 1'b0;
    #1;
    chk("midrst_valid_drop", out_valid, 0);
    chk("midrst_out0r", out0r, 0);
    chk("midrst_ovf", ovf, 0);
    tick();
    resetn = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("midrst_flush_valid_t%0d", t), out_valid, 0);
      chk($sformatf("midrst_flush_ovf_t%0d", t), ovf, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/butterfly_radix4_pipe.md
Name: butterfly_radix4_pipe

Overview:
- Fully pipelined, parametrised radix-4 DIF butterfly; successor to the multi-cycle start/done radix-4 butterfly.
- Accepts one 4-point complex set plus three twiddles per clock and emits results a fixed LATENCY cycles later.
- Adds forward/inverse mode, per-sample output scaling, round-half-up, saturation and a sticky overflow flag.
- Sits in each radix-4 SDF stage between the delay-feedback commutator and the next stage.

Parameters:
- DATA_W, 32, signed data width of every real/imag input and output.
- TW_W, 16, signed twiddle width, Q1.(TW_W-1) format.
- LATENCY, 4, fixed pipeline depth in cycles; only the value 4 is supported.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  input set valid this cycle
- inv  in  1  0 = forward FFT, 1 = inverse; sampled with in_valid
- scale  in  2  extra right shift 0..2 (3 is treated as 2); sampled with in_valid
- ar, ai, br, bi, cr, ci, dr, di  in  DATA_W each  complex inputs a..d
- w0r, w0i, w1r, w1i, w2r, w2i  in  TW_W each  twiddles for outputs 1..3
- clear_ovf  in  1  synchronous clear of ovf
- out_valid  out  1  output set valid
- out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i  out  DATA_W each  results X0..X3
- ovf  out  1  sticky saturation flag

Behaviour:
- Reset (async assert, sync release): all output registers and pipeline registers go to 0; out_valid=0, ovf=0. Any data in flight is discarded.
- Throughput is one set per clock with no backpressure. in_valid is not required to be contiguous; bubbles propagate unchanged.
- out_valid is in_valid delayed exactly 4 cycles. Outputs hold their last value while out_valid=0.
- inv and scale travel down the pipeline with their data. They take effect per sample, with no flush required.
- Arithmetic, with j = +1 if inv=1 and -1 if inv=0:
  - X0 = a+b+c+d
  - X1 = (a + j*b - c - j*d)*w0
  - X2 = (a - b + c - d)*w1
  - X3 = (a - j*b - c + j*d)*w2
  - Forward: X1 = (a - jb - c + jd)*w0.
  - Sums are carried at DATA_W+2 bits.
  - Complex products are full precision: re = xr*wr - xi*wi, im = xr*wi + xi*wr.
- Rounding:
  - X1..X3: add 2^(TW_W-2+s), then arithmetic shift right by TW_W-1+s, where s is the effective scale.
  - X0: shift by s, adding 2^(s-1) when s>0.
- Saturation: results are clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp on a valid sample sets ovf the cycle that sample appears at the output.
- ovf stays 1 until clear_ovf=1. If clear_ovf and a new overflow occur in the same cycle, ovf is set (set wins).
- Pipeline stages:
  - S1: radix-2 sums a±c, b±d.
  - S2: second additions with ±j, giving four partials.
  - S3: twiddle multiplies; X0 is passed through.
  - S4: round, scale, saturate, output registers.
- Twiddle -2^(TW_W-1) is exactly -1.0. +1.0 is not representable; X0 bypasses the multiplier.

Test Plan:
1. Reset: hold resetn=0 with random inputs and in_valid=1 -> out_valid=0, all outputs 0, ovf=0. Release resetn -> first out_valid occurs 4 cycles after the first sampled in_valid.
2. a=(100,0), b=c=d=0, all w=(16384,0), scale=0, inv=0 -> X0=(100,0) and X1=X2=X3=(50,0) (50.5 rounds down after floor-shift of 1654784>>15), 4 cycles after the input.
3. b=(10,0), a=c=d=0, all w=(-32768,0), inv=0 -> X0=(10,0), X1=(0,10), X2=(10,0), X3=(0,-10). With inv=1 -> X1=(0,-10), X3=(0,10).
4. a=b=c=d=(2147483647,0), scale=0 -> out0r=2147483647, X2=0, ovf=1. Then clear_ovf, rerun with scale=2 -> out0r=2147483647 and ovf stays 0.
5. Streaming: 8 consecutive valid sets with a=(k,0) for k=1..8, one bubble after k=4, scale toggling 0/1 per sample -> out_valid pattern matches the input pattern delayed 4 cycles; out0r = k or round(k/2) per that sample's scale.
6. Reset mid-flight: 3 valid sets in the pipeline, pulse resetn low for 1 cycle -> out_valid drops immediately, none of the 3 sets ever appears, ovf=0.
